// File: rtl/mux5_pkg.sv
// Channel numbering and state encoding shared by both ends of the mux5in1/demux1in5 path.
// No logic: definitions only, so neither end adds latency or backpressure here.
package mux5_pkg;
    localparam int NCH    = 5;
    localparam int CNTR_W = 3;

    localparam logic [CNTR_W-1:0] CH_A = 3'd0;
    localparam logic [CNTR_W-1:0] CH_B = 3'd1;
    localparam logic [CNTR_W-1:0] CH_C = 3'd2;
    localparam logic [CNTR_W-1:0] CH_D = 3'd3;
    localparam logic [CNTR_W-1:0] CH_E = 3'd4;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_t;

    function automatic logic sel_legal(input logic [CNTR_W-1:0] sel);
        return sel <= CH_E;
    endfunction
endpackage

// File: rtl/demux1in5_if.sv
// Upstream word/select handshake plus the five downstream valid/ready holding channels.
// Carries no state; flow control is the ready/valid pairs it groups.
interface demux1in5_if #(
    parameter int DW = 8
);
    logic                               i_valid;
    logic                               o_ready;
    logic [mux5_pkg::CNTR_W-1:0]        i_cntr;
    logic [DW-1:0]                      i_data;
    logic [mux5_pkg::NCH*DW-1:0]        o_data;
    logic [mux5_pkg::NCH-1:0]           o_valid;
    logic [mux5_pkg::NCH-1:0]           i_ready;
    logic                               i_err_clr;
    logic                               o_err;
    logic [mux5_pkg::NCH*8-1:0]         o_cnt;

    modport master (
        output i_valid, i_cntr, i_data, i_ready, i_err_clr,
        input  o_ready, o_data, o_valid, o_err, o_cnt
    );

    modport slave (
        input  i_valid, i_cntr, i_data, i_ready, i_err_clr,
        output o_ready, o_data, o_valid, o_err, o_cnt
    );
endinterface

// File: rtl/demux_slot.sv
// One output channel: data register, valid flag and optional DEMUX5_CNT_EN accept counter.
// Write lands 1 clock later; a write wins over a same-cycle drain so the channel stays full.
module demux_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] wdat,
    input  logic          rdy,
    output logic [DW-1:0] dat,
    output logic          vld,
    output logic [7:0]    cnt
);
    always_ff @(posedge clk) begin
        if (rst) begin
            dat <= '0;
            vld <= 1'b0;
        end else if (wr) begin
            dat <= wdat;
            vld <= 1'b1;
        end else if (vld && rdy) begin
            vld <= 1'b0;
        end
    end

`ifdef DEMUX5_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (wr)
            cnt <= cnt + 8'd1;
    end
`else
    assign cnt = '0;
`endif
endmodule

// File: rtl/demux1in5.sv
// Registered 1-to-5 demux with select decode, illegal-select error trap and per-channel holding slots.
// 1-clock latency; o_ready is combinational per selected channel and low while trapped. Counters: DEMUX5_CNT_EN.
module demux1in5
    import mux5_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    demux1in5_if.slave  bus
);
    state_t            state;
    state_t            state_nxt;
    logic              legal;
    logic              ready;
    logic              err;
    logic              accept;
    logic [NCH-1:0]    sel_oh;
    logic [NCH-1:0]    wr;
    logic [NCH-1:0]    vld;
    logic [NCH*DW-1:0] dat;
    logic [NCH*8-1:0]  cnt;

    always_comb begin
        legal = sel_legal(bus.i_cntr);
        for (int n = 0; n < NCH; n++)
            sel_oh[n] = (bus.i_cntr == CNTR_W'(n));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // An illegal word arriving alongside the clear keeps the block trapped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: if (bus.i_valid && !legal) state_nxt = ST_ERR;
            ST_ERR: if (bus.i_err_clr && !(bus.i_valid && !legal)) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        err   = 1'b0;
        case (state)
            ST_RUN: ready = legal ? |(sel_oh & (~vld | bus.i_ready)) : 1'b1;
            ST_ERR: err   = 1'b1;
            default: ready = 1'b0;
        endcase
        accept = bus.i_valid & ready;
        wr     = {NCH{accept & legal}} & sel_oh;
    end

    for (genvar n = 0; n < NCH; n++) begin : g_slot
        demux_slot #(.DW(DW)) u_slot (
            .clk  (i_clk),
            .rst  (i_reset),
            .wr   (wr[n]),
            .wdat (bus.i_data),
            .rdy  (bus.i_ready[n]),
            .dat  (dat[n*DW +: DW]),
            .vld  (vld[n]),
            .cnt  (cnt[n*8 +: 8])
        );
    end

    assign bus.o_ready = ready;
    assign bus.o_err   = err;
    assign bus.o_valid = vld;
    assign bus.o_data  = dat;
    assign bus.o_cnt   = cnt;
endmodule

// File: tb/tb_demux1in5.sv
// Scoreboard bench for demux1in5: per-channel expected-word queues, error flag and counters as the reference model.
module tb_demux1in5;
    import mux5_pkg::*;

    localparam int DW = 8;
`ifdef DEMUX5_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux1in5_if #(.DW(DW)) bus ();
    demux1in5 #(.DW(DW)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q [NCH][$];
    bit            model_err = 1'b0;
    int unsigned   model_cnt [NCH];
    bit            armed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH*8-1:0] exp_cnt();
        logic [NCH*8-1:0] e;
        e = '0;
        if (CNT_EN)
            for (int n = 0; n < NCH; n++) e[n*8 +: 8] = model_cnt[n][7:0];
        return e;
    endfunction

    // Monitor: registered outputs against the model, and every drained word against its queue head.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (armed) begin
                logic [NCH-1:0] ev;
                for (int n = 0; n < NCH; n++) ev[n] = (exp_q[n].size() != 0);
                check("o_valid", 64'(bus.o_valid), 64'(ev));
                check("o_err", 64'(bus.o_err), 64'(model_err));
                check("o_cnt", 64'(bus.o_cnt), 64'(exp_cnt()));
                for (int n = 0; n < NCH; n++)
                    if (bus.o_valid[n] && bus.i_ready[n] && exp_q[n].size() != 0)
                        check($sformatf("drain_dat%0d", n), 64'(bus.o_data[n*DW +: DW]), 64'(exp_q[n].pop_front()));
            end
        end
    end

    // Runs after the monitor has popped this cycle's drains, so an empty queue means the slot can take a word.
    task automatic model_update();
        bit legal;
        bit exp_rdy;
        int ch;
        legal = (bus.i_cntr < 3'd5);
        ch    = int'(bus.i_cntr);
        if (rst) begin
            for (int n = 0; n < NCH; n++) begin
                exp_q[n].delete();
                model_cnt[n] = 0;
            end
            model_err = 1'b0;
            armed     = 1'b1;
            return;
        end
        if (!armed) return;
        exp_rdy = !model_err && (!legal || exp_q[ch].size() == 0);
        if (bus.i_valid || legal)
            check("o_ready", 64'(bus.o_ready), 64'(exp_rdy));
        if (bus.i_valid && exp_rdy) begin
            if (legal) begin
                exp_q[ch].push_back(bus.i_data);
                model_cnt[ch] = (model_cnt[ch] + 1) % 256;
            end else begin
                model_err = 1'b1;
            end
        end else if (model_err && bus.i_err_clr && !(bus.i_valid && !legal)) begin
            model_err = 1'b0;
        end
    endtask

    task automatic step(input bit v, input logic [2:0] c, input logic [7:0] d,
                        input logic [4:0] r, input bit clr, input bit rs);
        @(posedge clk);
        #1;
        bus.i_valid   = v;
        bus.i_cntr    = c;
        bus.i_data    = d;
        bus.i_ready   = r;
        bus.i_err_clr = clr;
        rst           = rs;
        #3;
        model_update();
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 8'h00, 5'b00000, 1'b0, 1'b0);
    endtask

    task automatic rand_step(input bit rs);
        bit         v;
        logic [2:0] c;
        bit         clr;
        v   = ($urandom % 10) < 7;
        c   = ($urandom % 20 == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
        clr = ($urandom % 5 == 0);
        if (clr && v && c >= 3'd5) clr = 1'b0;
        step(v, c, 8'($urandom), 5'($urandom), clr, rs);
    endtask

    initial begin
        bus.i_valid   = 1'b0;
        bus.i_cntr    = '0;
        bus.i_data    = '0;
        bus.i_ready   = '0;
        bus.i_err_clr = 1'b0;

        // Reset hold with random inputs
        for (int i = 0; i < 5; i++) rand_step(1'b1);
        step(1'b0, 3'd0, 8'h00, 5'b00000, 1'b0, 1'b1);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_data", 64'(bus.o_data), 64'd0);
        check("rst_err", 64'(bus.o_err), 64'd0);
        check("rst_cnt", 64'(bus.o_cnt), 64'd0);
        check("rst_ready", 64'(bus.o_ready), 64'd1);

        // Single route to channel 2, then drain
        step(1'b1, CH_C, 8'h5A, 5'b00000, 1'b0, 1'b0);
        idle();
        check("route_valid", 64'(bus.o_valid), 64'b00100);
        check("route_data", 64'(bus.o_data[2*DW +: DW]), 64'h5A);
        step(1'b0, 3'd0, 8'h00, 5'b00100, 1'b0, 1'b0);
        idle();
        check("drain_valid", 64'(bus.o_valid), 64'd0);

        // Backpressure on a full channel 4, then same-cycle pass-through
        step(1'b1, CH_E, 8'h22, 5'b00000, 1'b0, 1'b0);
        step(1'b1, CH_E, 8'h11, 5'b00000, 1'b0, 1'b0);
        check("bp_ready", 64'(bus.o_ready), 64'd0);
        step(1'b1, CH_E, 8'h11, 5'b10000, 1'b0, 1'b0);
        check("pass_ready", 64'(bus.o_ready), 64'd1);
        idle();
        check("pass_data", 64'(bus.o_data[4*DW +: DW]), 64'h11);
        check("pass_valid", 64'(bus.o_valid), 64'b10000);

        // Illegal select traps; clear restores service
        step(1'b1, 3'd6, 8'hEE, 5'b00000, 1'b0, 1'b0);
        idle();
        check("ill_err", 64'(bus.o_err), 64'd1);
        check("ill_ready", 64'(bus.o_ready), 64'd0);
        check("ill_valid", 64'(bus.o_valid), 64'b10000);
        step(1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, 1'b0);
        step(1'b1, CH_B, 8'h33, 5'b00000, 1'b0, 1'b0);
        check("clr_err", 64'(bus.o_err), 64'd0);
        check("clr_ready", 64'(bus.o_ready), 64'd1);
        idle();
        check("clr_valid", 64'(bus.o_valid), 64'b10010);
        step(1'b1, 3'd7, 8'h44, 5'b00000, 1'b1, 1'b0);
        idle();
        check("clr_vs_ill_err", 64'(bus.o_err), 64'd1);
        step(1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, 1'b0);

        // Counter wrap on channel 0, three words on channel 3
        step(1'b0, 3'd0, 8'h00, 5'b00000, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) step(1'b1, CH_A, 8'($urandom), 5'b00001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, CH_D, 8'($urandom), 5'b01000, 1'b0, 1'b0);
        idle();
        check("cnt_wrap", 64'(bus.o_cnt), CNT_EN ? 64'h00_03_00_00_00 : 64'd0);

        // Reset while trapped with channels 1 and 3 full
        step(1'b0, 3'd0, 8'h00, 5'b00000, 1'b0, 1'b1);
        step(1'b1, CH_B, 8'hAA, 5'b00000, 1'b0, 1'b0);
        step(1'b1, CH_D, 8'hBB, 5'b00000, 1'b0, 1'b0);
        step(1'b1, 3'd5, 8'hCC, 5'b00000, 1'b0, 1'b0);
        idle();
        check("err_state_valid", 64'(bus.o_valid), 64'b01010);
        check("err_state_err", 64'(bus.o_err), 64'd1);
        step(1'b0, 3'd0, 8'h00, 5'b00000, 1'b0, 1'b1);
        idle();
        check("mid_rst_valid", 64'(bus.o_valid), 64'd0);
        check("mid_rst_data", 64'(bus.o_data), 64'd0);
        check("mid_rst_err", 64'(bus.o_err), 64'd0);
        check("mid_rst_cnt", 64'(bus.o_cnt), 64'd0);
        check("mid_rst_ready", 64'(bus.o_ready), 64'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) rand_step(($urandom % 200) == 0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
